// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared FSM encoding, divide-by-zero convention and sign helpers
package calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIX  = 2'd3
  } div_state_t;

  // Helpers work on the widest supported operand; callers size-cast in and out.
  localparam int MAX_W = 64;

  localparam logic [MAX_W-1:0] DIV_ZERO_Q = '1;

  function automatic logic [MAX_W-1:0] neg_w(input logic [MAX_W-1:0] x);
    return ~x + MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] x, input logic is_neg);
    return is_neg ? neg_w(x) : x;
  endfunction

endpackage

// File: rtl/dflip_en.sv
// rtl/dflip_en.sv - enabled register with asynchronous active-high clear
module dflip_en #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring division step on the upper accumulator half
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_hi,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] acc_hi_next,
  output logic             q_bit
);

  logic [WIDTH:0]   rem_ext;
  logic [WIDTH-1:0] diff;

  // The shifted partial remainder can momentarily need WIDTH+1 bits; after a
  // successful subtract it is below the divisor again, so WIDTH bits suffice.
  always_comb begin
    rem_ext     = {acc_hi, in_bit};
    q_bit       = (rem_ext >= {1'b0, divisor});
    diff        = rem_ext[WIDTH-1:0] - divisor;
    acc_hi_next = q_bit ? diff : rem_ext[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_seq_param.sv
// rtl/divider_seq_param.sv - sequential restoring divider, signed/unsigned, with abort
module divider_seq_param
  import calc_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state_bits_q;
  div_state_t         state_q, state_d;
  logic               accept, kill, prep, run, fix;
  logic               flag_en, acc_en, cnt_en, out_en;
  logic               a_neg, b_neg, dz_now, ov_now;
  logic [WIDTH-1:0]   a_mag;

  logic [WIDTH-1:0]   a_q, b_q;
  logic               sgn_q;
  logic               dz_d, dz_q, ov_d, ov_q;
  logic               qneg_d, qneg_q, rneg_d, rneg_q;
  logic [WIDTH-1:0]   bmag_d, bmag_q;
  logic [2*WIDTH-1:0] acc_d, acc_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [WIDTH-1:0]   quotient_d, quotient_q, remainder_d, remainder_q;
  logic               div_by_zero_q, overflow_q;
  logic               done_d, done_q;

  logic [WIDTH-1:0]   step_hi, q_raw, r_raw;
  logic               step_bit;

  assign state_q = div_state_t'(state_bits_q);

  div_step #(.WIDTH(WIDTH)) u_step (
    .acc_hi      (acc_q[2*WIDTH-1:WIDTH]),
    .in_bit      (acc_q[WIDTH-1]),
    .divisor     (bmag_q),
    .acc_hi_next (step_hi),
    .q_bit       (step_bit)
  );

  always_comb begin
    accept = (state_q == ST_IDLE) && start;
    kill   = abort && (state_q != ST_IDLE);
    prep   = (state_q == ST_PREP);
    run    = (state_q == ST_RUN);
    fix    = (state_q == ST_FIX);

    a_neg  = sgn_q & a_q[WIDTH-1];
    b_neg  = sgn_q & b_q[WIDTH-1];
    a_mag  = WIDTH'(abs_w(MAX_W'(a_q), a_neg));
    bmag_d = WIDTH'(abs_w(MAX_W'(b_q), b_neg));
    dz_now = (b_q == '0);
    ov_now = sgn_q && (a_q == MIN_VAL) && (b_q == '1);

    // Flags are cleared on acceptance and resolved once the operands are latched.
    flag_en = accept | prep;
    dz_d    = accept ? 1'b0 : dz_now;
    ov_d    = accept ? 1'b0 : ov_now;
    qneg_d  = a_neg ^ b_neg;
    rneg_d  = a_neg;

    acc_en = prep | run;
    acc_d  = prep ? {{WIDTH{1'b0}}, a_mag}
                  : {step_hi, acc_q[WIDTH-2:0], step_bit};
    cnt_en = prep | run;
    cnt_d  = prep ? '0 : cnt_q + CNT_W'(1);

    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_PREP;
      ST_PREP: state_d = (dz_now || ov_now) ? ST_FIX : ST_RUN;
      ST_RUN:  if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (kill) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end

    q_raw = acc_q[WIDTH-1:0];
    r_raw = acc_q[2*WIDTH-1:WIDTH];
    if (dz_q) begin
      quotient_d  = WIDTH'(DIV_ZERO_Q);
      remainder_d = a_q;
    end else if (ov_q) begin
      quotient_d  = MIN_VAL;
      remainder_d = '0;
    end else begin
      quotient_d  = qneg_q ? WIDTH'(neg_w(MAX_W'(q_raw))) : q_raw;
      remainder_d = rneg_q ? WIDTH'(neg_w(MAX_W'(r_raw))) : r_raw;
    end
    out_en = fix & ~abort;
  end

  dflip_en #(.W(2))       u_state (.clk(clk), .rst(rst), .en(1'b1),    .d(state_d),   .q(state_bits_q));
  dflip_en #(.W(WIDTH))   u_a     (.clk(clk), .rst(rst), .en(accept),  .d(dividend),  .q(a_q));
  dflip_en #(.W(WIDTH))   u_b     (.clk(clk), .rst(rst), .en(accept),  .d(divisor),   .q(b_q));
  dflip_en #(.W(1))       u_sgn   (.clk(clk), .rst(rst), .en(accept),  .d(op_signed), .q(sgn_q));
  dflip_en #(.W(1))       u_dz    (.clk(clk), .rst(rst), .en(flag_en), .d(dz_d),      .q(dz_q));
  dflip_en #(.W(1))       u_ov    (.clk(clk), .rst(rst), .en(flag_en), .d(ov_d),      .q(ov_q));
  dflip_en #(.W(1))       u_qneg  (.clk(clk), .rst(rst), .en(prep),    .d(qneg_d),    .q(qneg_q));
  dflip_en #(.W(1))       u_rneg  (.clk(clk), .rst(rst), .en(prep),    .d(rneg_d),    .q(rneg_q));
  dflip_en #(.W(WIDTH))   u_bmag  (.clk(clk), .rst(rst), .en(prep),    .d(bmag_d),    .q(bmag_q));
  dflip_en #(.W(2*WIDTH)) u_acc   (.clk(clk), .rst(rst), .en(acc_en),  .d(acc_d),     .q(acc_q));
  dflip_en #(.W(CNT_W))   u_cnt   (.clk(clk), .rst(rst), .en(cnt_en),  .d(cnt_d),     .q(cnt_q));
  dflip_en #(.W(WIDTH))   u_quo   (.clk(clk), .rst(rst), .en(out_en),  .d(quotient_d),  .q(quotient_q));
  dflip_en #(.W(WIDTH))   u_rem   (.clk(clk), .rst(rst), .en(out_en),  .d(remainder_d), .q(remainder_q));
  dflip_en #(.W(1))       u_dzo   (.clk(clk), .rst(rst), .en(out_en),  .d(dz_q),      .q(div_by_zero_q));
  dflip_en #(.W(1))       u_ovo   (.clk(clk), .rst(rst), .en(out_en),  .d(ov_q),      .q(overflow_q));
  dflip_en #(.W(1))       u_done  (.clk(clk), .rst(rst), .en(1'b1),    .d(done_d),    .q(done_q));

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_divider_seq_param.sv
// tb/tb_divider_seq_param.sv - self-checking bench for divider_seq_param (WIDTH=32)
module tb_divider_seq_param;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
  } res_t;

  logic         clk = 1'b0;
  logic         rst, start, abort, op_signed;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         busy, done, div_by_zero, overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  divider_seq_param #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op_signed(op_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Arithmetic reference: SV integer division already truncates toward zero
  // and gives the remainder the dividend's sign.
  function automatic res_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t res;
    int   sa, sb;
    res = '0;
    if (b == '0) begin
      res.q  = '1;
      res.r  = a;
      res.dz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res.q  = a;
      res.r  = '0;
      res.ov = 1'b1;
    end else if (s) begin
      sa    = a;
      sb    = b;
      res.q = sa / sb;
      res.r = sa % sb;
    end else begin
      res.q = a / b;
      res.r = a % b;
    end
    return res;
  endfunction

  function automatic int lat_of(input res_t res);
    return (res.dz || res.ov) ? 2 : W + 2;
  endfunction

  logic m_busy   = 1'b0;
  logic exp_done = 1'b0;
  int   cyc      = 0;
  int   due      = 0;
  res_t held     = '0;
  res_t pend     = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy   <= 1'b0;
      exp_done <= 1'b0;
      held     <= '0;
    end else begin
      cyc      <= cyc + 1;
      exp_done <= 1'b0;
      if (m_busy) begin
        if (abort) begin
          m_busy <= 1'b0;
        end else if (cyc == due) begin
          m_busy   <= 1'b0;
          exp_done <= 1'b1;
          held     <= pend;
        end
      end else if (start) begin
        pend   <= model(op_signed, dividend, divisor);
        due    <= cyc + lat_of(model(op_signed, dividend, divisor));
        m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk1("cyc_busy", busy, m_busy);
    chk1("cyc_done", done, exp_done);
    chk("cyc_quotient", quotient, held.q);
    chk("cyc_remainder", remainder, held.r);
    chk1("cyc_div_by_zero", div_by_zero, held.dz);
    chk1("cyc_overflow", overflow, held.ov);
  end

  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    op_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 200);
  endtask

  task automatic do_op(input string name, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                       input logic eov, input int elat);
    int n;
    issue(s, a, b);
    wait_done(n);
    chk({name, "_latency"}, W'(n), W'(elat));
    chk({name, "_q"}, quotient, eq);
    chk({name, "_r"}, remainder, er);
    chk1({name, "_dz"}, div_by_zero, edz);
    chk1({name, "_ov"}, overflow, eov);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    res_t mr;
    rst = 1'b1; start = 1'b0; abort = 1'b0; op_signed = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q", quotient, 32'h0);
    chk("reset_r", remainder, 32'h0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk1("reset_flags", div_by_zero | overflow, 1'b0);
    rst = 1'b0;

    mr = model(1'b0, 32'd100, 32'd7);
    chk("model_u100_7_q", mr.q, 32'd14);
    chk("model_u100_7_r", mr.r, 32'd2);
    mr = model(1'b1, 32'hFFFF_FF9C, 32'd7);
    chk("model_sm100_7_q", mr.q, 32'hFFFF_FFF2);
    chk("model_sm100_7_r", mr.r, 32'hFFFF_FFFE);
    mr = model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("model_ovf_q", mr.q, 32'h8000_0000);
    chk1("model_ovf_flag", mr.ov, 1'b1);
    mr = model(1'b0, 32'd5, 32'd0);
    chk1("model_dz_flag", mr.dz, 1'b1);

    do_op("u100_7",    1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0, 34);
    do_op("s-100_7",   1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 34);
    do_op("s100_-7",   1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         1'b0, 1'b0, 34);
    do_op("u5_0",      1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1, 1'b0, 2);
    do_op("s5_0",      1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1, 1'b0, 2);
    do_op("s_ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 1'b1, 2);
    do_op("u_min_m1",  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 1'b0, 34);
    do_op("u_max_1",   1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0, 34);
    do_op("s-5_0",     1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0, 2);
    do_op("s_min_2",   1'b1, 32'h8000_0000, 32'd2,         32'hC000_0000, 32'd0,         1'b0, 1'b0, 34);
    do_op("u0_5",      1'b0, 32'd0,         32'd5,         32'd0,         32'd0,         1'b0, 1'b0, 34);
    do_op("s-7_-2",    1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0, 1'b0, 34);

    issue(1'b0, 32'd1000, 32'd3);
    repeat (11) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    repeat (40) begin @(posedge clk); #1; end
    chk("abort_held_q", quotient, 32'd3);
    chk("abort_held_r", remainder, 32'hFFFF_FFFF);

    issue(1'b0, 32'd50, 32'd5);
    repeat (5) begin @(posedge clk); #1; end
    op_signed = 1'b1; dividend = 32'd77; divisor = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    chk("busy_start_latency", W'(n + 6), 32'd34);
    chk("busy_start_q", quotient, 32'd10);
    chk1("busy_start_dz", div_by_zero, 1'b0);

    abort = 1'b1;
    issue(1'b0, 32'd9, 32'd4);
    abort = 1'b0;
    wait_done(n);
    chk("abort_start_latency", W'(n), 32'd34);
    chk("abort_start_q", quotient, 32'd2);
    chk("abort_start_r", remainder, 32'd1);

    issue(1'b0, 32'd200, 32'd9);
    wait_done(n);
    chk("b2b_first_q", quotient, 32'd22);
    issue(1'b1, 32'hFFFF_FF38, 32'd9);
    wait_done(n);
    chk("b2b_latency", W'(n), 32'd34);
    chk("b2b_q", quotient, 32'hFFFF_FFEA);
    chk("b2b_r", remainder, 32'hFFFF_FFFE);

    issue(1'b0, 32'd12345, 32'd6);
    repeat (8) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("rst_mid_q", quotient, 32'h0);
    chk("rst_mid_r", remainder, 32'h0);
    chk1("rst_mid_busy", busy, 1'b0);
    chk1("rst_mid_flags", div_by_zero | overflow | done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op("after_rst", 1'b0, 32'd12345, 32'd6, 32'd2057, 32'd3, 1'b0, 1'b0, 34);

    repeat (3) begin @(posedge clk); #1; end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
